// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video enable and sync strobes.
// Define VIDEO_TIMING_DELAY_EN to delay the strobes (not the counters) by DELAY enabled cycles.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12,
    parameter int unsigned DELAY    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          vde,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    cd,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

    if ((H_TOTAL > (64'd1 << CW)) || (V_TOTAL > (64'd1 << CW)) || (DELAY < 1)) begin : g_param_check
        $error("video_timing_gen: CW too narrow for totals, or DELAY below 1");
    end

    typedef struct packed {
        logic vde;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = strobe_t'{1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0};

    logic [CW-1:0] h_next_c;
    logic [CW-1:0] v_next_c;
    strobe_t       strb_next_c;
    strobe_t       strb_q;
    strobe_t       strb_out_c;

    // Next raster position and the strobes that describe it.
    always_comb begin
        h_next_c    = h_count;
        v_next_c    = v_count;
        strb_next_c = STROBE_IDLE;
        if (h_count == CW'(H_TOTAL - 1)) begin
            h_next_c = '0;
            v_next_c = (v_count == CW'(V_TOTAL - 1)) ? '0 : v_count + CW'(1);
        end else begin
            h_next_c = h_count + CW'(1);
        end
        strb_next_c.vde         = (h_next_c < CW'(H_ACTIVE)) && (v_next_c < CW'(V_ACTIVE));
        strb_next_c.hsync       = ((h_next_c >= CW'(H_SYNC_BEG)) && (h_next_c < CW'(H_SYNC_END)))
                                  ? HS_POL : ~HS_POL;
        strb_next_c.vsync       = ((v_next_c >= CW'(V_SYNC_BEG)) && (v_next_c < CW'(V_SYNC_END)))
                                  ? VS_POL : ~VS_POL;
        strb_next_c.line_start  = (h_next_c == '0);
        strb_next_c.frame_start = (h_next_c == '0) && (v_next_c == '0);
    end

    // Reset parks the raster on the last blanking pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= CW'(H_TOTAL - 1);
            v_count <= CW'(V_TOTAL - 1);
            strb_q  <= STROBE_IDLE;
        end else if (en) begin
            h_count <= h_next_c;
            v_count <= v_next_c;
            strb_q  <= strb_next_c;
        end
    end

`ifdef VIDEO_TIMING_DELAY_EN
    strobe_t dly_q [DELAY];

    // Strobe alignment line; counters stay early to address the pixel pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                dly_q[i] <= STROBE_IDLE;
            end
        end else if (en) begin
            dly_q[0] <= strb_q;
            for (int i = 1; i < int'(DELAY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign strb_out_c = dly_q[DELAY-1];
`else
    assign strb_out_c = strb_q;
`endif

    assign vde         = strb_out_c.vde;
    assign hsync       = strb_out_c.hsync;
    assign vsync       = strb_out_c.vsync;
    assign cd          = {strb_out_c.vsync, strb_out_c.hsync};
    assign line_start  = strb_out_c.line_start;
    assign frame_start = strb_out_c.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 16x12 raster (default build, no strobe delay).
module tb_video_timing_gen;

    localparam int unsigned CW    = 12;
    localparam int          HT    = 16;   // 8 active + 2 fp + 3 sync + 3 bp
    localparam int          VT    = 12;   // 6 active + 2 fp + 2 sync + 2 bp
    localparam int          FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          vde;
    logic          hsync;
    logic          vsync;
    logic [1:0]    cd;
    logic          line_start;
    logic          frame_start;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .DELAY(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .h_count(h_count),
        .v_count(v_count),
        .vde(vde),
        .hsync(hsync),
        .vsync(vsync),
        .cd(cd),
        .line_start(line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mh, mv;
    int   cyc, last_fs, last_ls;
    logic prev_vs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    // Expected strobes: active h 0..7 / v 0..5, hsync low h 10..12, vsync low lines 8..9.
    task automatic expect_outputs(input string tag);
        logic e_vde, e_hs, e_vs;
        e_vde = (mh < 8) && (mv < 6);
        e_hs  = !((mh >= 10) && (mh <= 12));
        e_vs  = !((mv == 8) || (mv == 9));
        check({tag, "_h"},   32'(h_count),     32'(mh));
        check({tag, "_v"},   32'(v_count),     32'(mv));
        check({tag, "_vde"}, 32'(vde),         32'(e_vde));
        check({tag, "_hs"},  32'(hsync),       32'(e_hs));
        check({tag, "_vs"},  32'(vsync),       32'(e_vs));
        check({tag, "_cd"},  32'(cd),          32'({e_vs, e_hs}));
        check({tag, "_ls"},  32'(line_start),  32'(mh == 0));
        check({tag, "_fs"},  32'(frame_start), 32'((mh == 0) && (mv == 0)));
    endtask

    task automatic tick(input string tag);
        logic adv;
        @(posedge clk);
        adv = en && !reset;
        @(negedge clk);
        if (adv) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            cyc++;
            if (frame_start) begin
                if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                last_fs = cyc;
            end
            if (line_start) begin
                if (last_ls >= 0) check("line_period", 32'(cyc - last_ls), 32'(HT));
                last_ls = cyc;
            end
        end
        if (vsync !== prev_vs) check("vsync_change_at_h0", 32'(h_count), 32'd0);
        prev_vs = vsync;
        expect_outputs(tag);
    endtask

    task automatic run_to(input int th, input int tv);
        int n;
        n = 0;
        while (((mh != th) || (mv != tv)) && (n < 1000)) begin
            tick("seek");
            n++;
        end
        check("seek_h", 32'(h_count), 32'(th));
        check("seek_v", 32'(v_count), 32'(tv));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},   32'(h_count),     32'd15);
        check({tag, "_v"},   32'(v_count),     32'd11);
        check({tag, "_vde"}, 32'(vde),         32'd0);
        check({tag, "_hs"},  32'(hsync),       32'd1);
        check({tag, "_vs"},  32'(vsync),       32'd1);
        check({tag, "_cd"},  32'(cd),          32'd3);
        check({tag, "_ls"},  32'(line_start),  32'd0);
        check({tag, "_fs"},  32'(frame_start), 32'd0);
    endtask

    initial begin
        int n_vde, n_hs, n_vs, n_ls, n_fs;

        repeat (2) @(negedge clk);
        check_reset_state("rst");
        mh = HT - 1; mv = VT - 1;
        cyc = 0; last_fs = -1; last_ls = -1; prev_vs = vsync;

        reset = 1'b0;
        en    = 1'b1;
        tick("first");

        // One full frame of strobe statistics starting at (0,0).
        n_vde = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i != 0) tick("frame");
            n_vde += int'(vde);
            n_hs  += int'(!hsync);
            n_vs  += int'(!vsync);
            n_ls  += int'(line_start);
            n_fs  += int'(frame_start);
        end
        check("frame_vde_cycles",   32'(n_vde), 32'd48);
        check("frame_hsync_cycles", 32'(n_hs),  32'd36);
        check("frame_vsync_cycles", 32'(n_vs),  32'd32);
        check("frame_line_starts",  32'(n_ls),  32'd12);
        check("frame_frame_starts", 32'(n_fs),  32'd1);

        // Second frame exercises the 11->0 wrap and frame/line periods.
        repeat (FRAME) tick("frame2");

        // Freeze on the last active pixel of a line.
        run_to(7, 1);
        en = 1'b0;
        repeat (10) tick("hold");
        check("hold_vde", 32'(vde), 32'd1);
        en = 1'b1;
        tick("resume");
        check("resume_h",   32'(h_count), 32'd8);
        check("resume_vde", 32'(vde),     32'd0);

        // Pulses hold too.
        run_to(0, 2);
        en = 1'b0;
        repeat (3) tick("hold_ls");
        check("hold_line_start", 32'(line_start), 32'd1);
        en = 1'b1;

        // Asynchronous reset between edges while in both sync windows.
        run_to(11, 8);
        check("pre_rst_hs", 32'(hsync), 32'd0);
        check("pre_rst_vs", 32'(vsync), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        check_reset_state("rst_held");
        reset = 1'b0;
        mh = HT - 1; mv = VT - 1;
        last_fs = -1; last_ls = -1; prev_vs = vsync;
        tick("post_rst");
        repeat (HT + 2) tick("post_run");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI output path: horizontal and vertical pixel counters, active-video enable, and HSYNC/VSYNC.
- Sits directly upstream of the three TMDS channel encoders.
  - Its `vde` drives each encoder's video-data-enable input.
  - Its `cd` drives the blue encoder's 2-bit control-data input.
  - Its counters address the pixel source (the Mandelbrot LUT pipeline).
- Runs in the pixel clock domain. It advances one pixel per enabled clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync (0 = active-low)
- CW, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- DELAY, 4, alignment delay in enabled cycles; used only with the optional feature; must be at least 1

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  pixel advance enable; when low, all state holds
- h_count  out  CW  current pixel x position, 0..H_TOTAL-1
- v_count  out  CW  current line y position, 0..V_TOTAL-1
- vde  out  1  active video: high when h_count<H_ACTIVE and v_count<V_ACTIVE
- hsync  out  1  horizontal sync at HS_POL polarity
- vsync  out  1  vertical sync at VS_POL polarity
- cd  out  2  {vsync, hsync}, for the blue TMDS encoder control input
- line_start  out  1  high while h_count==0
- frame_start  out  1  high while h_count==0 and v_count==0

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (async, takes effect immediately, including mid-frame):
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1, so the raster parks on the last blanking pixel of the frame.
  - vde=0, hsync=~HS_POL, vsync=~VS_POL, cd={~VS_POL,~HS_POL}.
  - line_start=0, frame_start=0.
- Counter update on each rising clk with en=1:
  - If h_count==H_TOTAL-1: h_count←0, and v_count←(v_count==V_TOTAL-1) ? 0 : v_count+1.
  - Otherwise: h_count←h_count+1, v_count holds.
- en=0: every register holds, and so does every output, including the pulses.
- All outputs are registers. Decodes are computed from the next counter value, so every output in a given cycle describes the same (h_count, v_count). There is zero relative skew between counters and strobes.
- The first enabled edge after reset yields (0,0) with vde=1, line_start=1, frame_start=1.
- hsync is asserted (=HS_POL) when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC. Default: 656..751.
- vsync is asserted (=VS_POL) for the whole of every line where V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC. Default: lines 490..491. It changes level only when h_count==0.
- cd mirrors the registered hsync/vsync output levels exactly.
- The downstream encoder register adds one further cycle. This block does not compensate for that cycle unless the optional feature is compiled in.
- Widths: comparisons are unsigned at CW bits. Parameter sums must be computed at 32 bits before comparing.

Optional Feature:
- Macro: VIDEO_TIMING_DELAY_EN.
- Defined:
  - vde, hsync, vsync, cd, line_start and frame_start pass through a DELAY-stage shift line before reaching the ports.
  - The shift line advances only when en=1.
  - h_count and v_count are NOT delayed. They address the pixel pipeline, and the strobes then line up with pixel data arriving DELAY enabled cycles later.
  - Reset loads every stage with the inactive reset values above.
  - For the first DELAY enabled cycles after reset, the strobes show blanking.
- Undefined: no delay line; the strobes are as described in Behaviour; the DELAY parameter is ignored.

Test Plan:
1. Assert reset at h_count=300, v_count=100 between clock edges. Required immediately, without waiting for a clock edge: h_count=799, v_count=524, vde=0, hsync=1, vsync=1, cd=2'b11. Release reset with en=1; the first edge gives (0,0) with vde=1, line_start=1, frame_start=1.
2. Free-run one line with en=1. Required: vde high for exactly 640 consecutive cycles from h=0; hsync=0 for h=656..751 (96 cycles); line_start pulses once every 800 cycles.
3. Free-run one frame. Required: vsync=0 for lines 490..491 (1600 cycles), changing only at h_count=0; vde never high on lines 480..524; v wraps 524→0 at h 799→0; frame_start recurs every 420000 cycles.
4. Hold en=0 for 10 cycles at h=639, v=10. Required: all outputs frozen with vde=1. On resuming en=1: h=640, vde=0.
5. With VIDEO_TIMING_DELAY_EN defined and DELAY=4, from reset release with en=1:
   - h_count=0 on edge 1, vde rises on edge 5.
   - A 3-cycle en=0 gap stretches the alignment identically.
   - Reset mid-stream clears every stage to vde=0, hsync=1 immediately.
